// File: rtl/weight_loader.sv
// Purpose: packs a serial stream of signed 2-bit weights into K2-wide kernel vectors and writes one per feature.
// Latency: K2 transfers + 1 WRITE cycle per feature; start + NUM_FEATURES*(K2+1) + 1 DONE cycle per load.
// Backpressure: w_ready is high only in LOAD; w_valid gaps stretch LOAD, and there is no timeout.
//
// Ports:
//   clk, rst        - single clock (posedge) and asynchronous active-low reset
//   start           - one-cycle load request, honoured only while idle
//   w_valid/w_ready - stream handshake; w_data is the signed 2-bit weight
//   address_w       - feature index being written (doubles as the feature counter)
//   feature_WrEn    - active-low write strobe, low for the single WRITE cycle
//   weights_input   - assembled kernel vector, element 0 = first beat of the feature
//   busy, done      - busy outside IDLE; done pulses for one cycle after the last write
//   range_err       - sticky illegal-weight (-2) flag, built only with WEIGHT_LOADER_RANGE_CHECK_EN
//
// All write-side outputs come straight from posedge flops, so the memory, which
// captures on the falling edge, always sees them settled.
module weight_loader #(
  parameter int KERNEL_SIZE  = 3,
  parameter int NUM_FEATURES = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              w_valid,
  input  logic signed [1:0]                 w_data,
  output logic                              w_ready,
  output logic [$clog2(NUM_FEATURES):0]     address_w,
  output logic                              feature_WrEn,
  output logic signed [1:0]                 weights_input [KERNEL_SIZE*KERNEL_SIZE],
  output logic                              busy,
  output logic                              done,
  output logic                              range_err
);

  localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BW = (K2 > 1) ? $clog2(K2) : 1;
  localparam int AW = $clog2(NUM_FEATURES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      address_w    <= '0;
      feature_WrEn <= 1'b1;
      w_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < K2; i++) weights_input[i] <= '0;
`ifdef WEIGHT_LOADER_RANGE_CHECK_EN
      range_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            address_w <= '0;
            beat_cnt  <= '0;
            w_ready   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LOAD;
`ifdef WEIGHT_LOADER_RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
          end
        end
        // w_ready is registered high for the whole of LOAD, so w_valid alone
        // marks a transfer here.
        S_LOAD: begin
          if (w_valid) begin
            for (int i = 0; i < K2; i++) begin
              if (beat_cnt == BW'(i)) weights_input[i] <= w_data;
            end
`ifdef WEIGHT_LOADER_RANGE_CHECK_EN
            if (w_data == 2'sb10) range_err <= 1'b1;
`endif
            if (beat_cnt == BW'(K2 - 1)) begin
              beat_cnt     <= '0;
              w_ready      <= 1'b0;
              feature_WrEn <= 1'b0;
              state        <= S_WRITE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          feature_WrEn <= 1'b1;
          if (address_w == AW'(NUM_FEATURES - 1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            address_w <= address_w + 1'b1;
            w_ready   <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef WEIGHT_LOADER_RANGE_CHECK_EN
  assign range_err = 1'b0;
`endif

endmodule

// File: doc/weight_loader.md
# weight_loader

- Upstream feeder for the feature weight memory.
- Accepts a serial valid/ready stream of signed 2-bit kernel weights.
- Assembles each group of KERNEL_SIZE*KERNEL_SIZE weights into one parallel kernel vector.
- Issues one active-low write per feature, filling features 0..NUM_FEATURES-1 after each `start`.
- The memory it feeds captures writes on the falling clock edge. This block drives all write-side outputs from rising-edge registers, so they are stable across that falling edge.

## Interface
Parameters:
- KERNEL_SIZE, 3, kernel side length; K2 = KERNEL_SIZE*KERNEL_SIZE weights per feature
- NUM_FEATURES, 10, number of features loaded per `start`

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a full load; sampled only in IDLE
- w_valid  in  1  stream beat valid
- w_data  in  signed [1:0]  stream weight
- w_ready  out  1  block accepts a beat this cycle
- address_w  out  [$clog2(NUM_FEATURES):0]  feature index being written
- feature_WrEn  out  1  active-low write strobe to the weight memory
- weights_input  out  signed [1:0] x K2 (unpacked array)  assembled kernel vector
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last feature write
- range_err  out  1  sticky illegal-weight flag (see Configuration)

## Operation
- A beat transfers on a posedge where w_valid && w_ready.
- FSM states and transitions:
  - IDLE: w_ready=0. When start=1: clear feat_cnt, clear beat_cnt, clear range_err, go to LOAD.
  - LOAD: w_ready=1. On each transfer, weights_input[beat_cnt] <= w_data and beat_cnt increments. The transfer with beat_cnt==K2-1 goes to WRITE and resets beat_cnt to 0.
  - WRITE: w_ready=0; feature_WrEn=0 for exactly this one cycle.
    - If feat_cnt==NUM_FEATURES-1: go to DONE.
    - Otherwise: feat_cnt+1, go to LOAD.
  - DONE: done=1 for one cycle, then go to IDLE.
- Outputs and fill order:
  - address_w = feat_cnt, zero-extended; never reaches NUM_FEATURES.
  - Element index 0 of weights_input is filled by the first beat of each feature.
- Hold and ignore rules:
  - weights_input holds its value outside LOAD transfers, including through WRITE, DONE and IDLE.
  - start is ignored while busy.
  - Beats offered while w_ready=0 are not consumed.
- Counter widths: beat_cnt is $clog2(K2) bits; feat_cnt matches the address_w width. No wrap-around occurs because of the explicit terminal compares.

## Timing
- Reset values (rst=0, asynchronous):
  - state=IDLE
  - feature_WrEn=1
  - address_w=0
  - weights_input all 0
  - w_ready=0, busy=0, done=0, range_err=0
- Reset mid-operation: immediate abort with the values above. No partial write is issued. The memory keeps previously written features.
- Per-feature latency with w_valid held high: K2 transfer cycles + 1 WRITE cycle. Defaults: 10 cycles per feature.
- Full load with w_valid held high: start cycle + NUM_FEATURES*(K2+1) + 1 DONE cycle. Defaults: 102 cycles from the start posedge to done deasserting.
- Stalls: w_valid gaps stretch LOAD only. The FSM does not time out.
- During the WRITE cycle, address_w and weights_input are stable from the preceding posedge through the following posedge.

## Configuration
- Macro: WEIGHT_LOADER_RANGE_CHECK_EN.
- Defined:
  - Weights are ternary, so a transferred w_data==2'b10 (-2) sets range_err.
  - range_err stays set until the next accepted start or reset.
  - The weight is still stored and written unmodified.
- Undefined: range_err is tied to 0 and no checking logic is built.

## Test plan
- Reset check: assert rst=0 mid-LOAD at feature 3, beat 5. Outputs immediately take their reset values; feature_WrEn never pulses low. After release, start reloads from feature 0.
- Full load, defaults, w_valid held high, beats cycling 0,1,-1: exactly 10 low pulses on feature_WrEn, with address_w 0..9 in order. Each weights_input matches its 9 beats in order. done pulses once, at cycle 102.
- Backpressure: toggle w_valid at random. Exactly 9 beats are consumed per feature. w_ready=0 during WRITE, DONE and IDLE; no beat is lost or duplicated.
- start=1 while busy has no effect. A second start after done produces a fresh sequence starting at address_w=0.
- With WEIGHT_LOADER_RANGE_CHECK_EN defined, send -2 as beat 4 of feature 2: range_err rises on the following cycle and stays set through done. Weight value -2 appears at weights_input[4] during the address 2 write. The next start clears range_err. Without the macro, range_err stays 0 throughout.
- Parameter sweep with KERNEL_SIZE=2, NUM_FEATURES=1: 4 beats, one write to address 0, done 7 cycles after start.
